// File: rtl/regfile_pkg.sv
// Shared defaults for the multi-port register file and its scoreboard.
// Build option: define REGFILE_BYPASS_EN for write-through forwarding to the read ports.
package regfile_pkg;

    localparam int REGFILE_DATA_W    = 32;
    localparam int REGFILE_ADDR_W    = 5;
    localparam int REGFILE_NUM_RD    = 2;
    localparam int REGFILE_NUM_WR    = 2;
    localparam int REGFILE_ZERO_ADDR = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits: writeback releases, dispatch reserves (reserve wins),
// and a sticky flag records a reservation of a register that was already outstanding.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REGFILE_ADDR_W,
    parameter int NUM_WR = REGFILE_NUM_WR
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic                     rsv_en_i,
    input  logic [ADDR_W-1:0]        rsv_addr_i,
    output logic [(1<<ADDR_W)-1:0]   busy_o,
    output logic                     err_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REGFILE_ZERO_ADDR);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic             err_q, err_d;
    logic             rsv_valid;

    assign rsv_valid = rsv_en_i && (rsv_addr_i != ZERO);

    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] != ZERO)) begin
                busy_d[wr_addr_i[w*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        // Applied after the releases so a same-cycle reserve leaves the new producer outstanding.
        if (rsv_valid) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
        err_d = err_q | (rsv_valid && busy_q[rsv_addr_i]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign busy_o = busy_q;
    assign err_o  = err_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with r0 hardwired to zero and a pending-write scoreboard.
// Build option: REGFILE_BYPASS_EN forwards same-cycle writes to reads and masks busy.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int ADDR_W = REGFILE_ADDR_W,
    parameter int NUM_RD = REGFILE_NUM_RD,
    parameter int NUM_WR = REGFILE_NUM_WR
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic                     rsv_en_i,
    input  logic [ADDR_W-1:0]        rsv_addr_i,
    output logic                     err_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REGFILE_ZERO_ADDR);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy;

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .rsv_en_i   (rsv_en_i),
        .rsv_addr_i (rsv_addr_i),
        .busy_o     (busy),
        .err_o      (err_o)
    );

    // Ports are applied in ascending order so the highest-index port wins a collision.
    always_comb begin
        mem_d = mem_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] != ZERO)) begin
                mem_d[wr_addr_i[w*ADDR_W +: ADDR_W]] = wr_data_i[w*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data_o[p*DATA_W +: DATA_W] = mem_q[rd_addr_i[p*ADDR_W +: ADDR_W]];
            rd_busy_o[p]                  = busy[rd_addr_i[p*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] != ZERO) &&
                    (wr_addr_i[w*ADDR_W +: ADDR_W] == rd_addr_i[p*ADDR_W +: ADDR_W])) begin
                    rd_data_o[p*DATA_W +: DATA_W] = wr_data_i[w*DATA_W +: DATA_W];
                    rd_busy_o[p]                  = 1'b0;
                end
            end
`endif
        end
        // Forwarded write data must not leak out while reset is held.
        if (rst_i) begin
            rd_data_o = '0;
            rd_busy_o = '0;
        end
    end

endmodule
